// File: rtl/frame_burst_pkg.sv
// Shared types, default constants and the write-guard window helper for
// frame_burst_mem.
package frame_burst_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    RESUME
  } burst_state_t;

  localparam int unsigned DEFAULT_BURST_BASE = 32'h1000;
  localparam int unsigned DEFAULT_BURST_LEN  = 32'd64;

  // True when addr falls inside [base, base+len) modulo 2**aw.
  function automatic logic in_window(input int unsigned addr,
                                     input int unsigned base,
                                     input int unsigned len,
                                     input int unsigned aw);
    int unsigned mask;
    int unsigned off;
    mask = (aw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << aw) - 32'd1);
    off  = (addr - base) & mask;
    return off < len;
  endfunction

endpackage

// File: rtl/frame_burst_mem_data_ram.sv
// data_ram: 16-bit word RAM, one synchronous write port and two
// asynchronous read ports (cpu and burst). Contents are not reset.
//   clk            clock
//   we/waddr/wdata write port, sampled at posedge
//   cpu_addr       cpu read address   -> cpu_rdata_c (combinational)
//   burst_addr     burst read address -> burst_rdata_c (combinational)
module data_ram #(
  parameter int unsigned DATA_ADDR_WIDTH = 13
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [DATA_ADDR_WIDTH-1:0] waddr,
  input  logic [15:0]                wdata,
  input  logic [DATA_ADDR_WIDTH-1:0] cpu_addr,
  output logic [15:0]                cpu_rdata_c,
  input  logic [DATA_ADDR_WIDTH-1:0] burst_addr,
  output logic [15:0]                burst_rdata_c
);

  localparam int unsigned DEPTH = 32'd1 << DATA_ADDR_WIDTH;

  logic [15:0] mem [DEPTH];

  // Reads see the pre-edge contents, so a same-cycle write returns old data.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign cpu_rdata_c   = mem[cpu_addr];
  assign burst_rdata_c = mem[burst_addr];

endmodule

// File: rtl/frame_burst_mem.sv
// frame_burst_mem: cpu data-memory responder that, on each frame_start,
// streams BURST_LEN words starting at BURST_BASE over valid/ready and then
// pulses resume for one cycle to wake the cpu.
//   clk, reset (async, active-low)
//   mem_din_addr/mem_din                   cpu async read port
//   mem_dout_we/mem_dout_addr/mem_dout     cpu sync write port
//   frame_start                            frame-boundary pulse
//   out_valid/out_ready/out_data/out_last  burst stream
//   resume                                 one-cycle cpu wake pulse
//   overrun                                sticky: frame_start while busy
// Optional macro DATA_MEM_WRITE_GUARD_EN: drops cpu writes into the burst
// window while streaming and adds sticky output write_conflict.
module frame_burst_mem
  import frame_burst_pkg::*;
#(
  parameter int unsigned DATA_ADDR_WIDTH = 13,
  parameter int unsigned BURST_BASE      = DEFAULT_BURST_BASE,
  parameter int unsigned BURST_LEN       = DEFAULT_BURST_LEN
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_ADDR_WIDTH-1:0] mem_din_addr,
  output logic [15:0]                mem_din,
  input  logic                       mem_dout_we,
  input  logic [DATA_ADDR_WIDTH-1:0] mem_dout_addr,
  input  logic [15:0]                mem_dout,
  input  logic                       frame_start,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                out_data,
  output logic                       out_last,
  output logic                       resume,
`ifdef DATA_MEM_WRITE_GUARD_EN
  output logic                       write_conflict,
`endif
  output logic                       overrun
);

  localparam int unsigned AW = DATA_ADDR_WIDTH;
  localparam logic [AW-1:0] BASE_ADDR = AW'(BURST_BASE);
  localparam logic [AW-1:0] LAST_IDX  = AW'(BURST_LEN - 32'd1);

  burst_state_t  state;
  logic [AW-1:0] idx;
  logic [AW-1:0] burst_addr_c;
  logic [15:0]   burst_word_c;
  logic          accept_c;
  logic          is_last_c;
  logic          next_last_c;
  logic          wr_en_c;
  logic [AW-1:0] idx_inc_c;

  assign accept_c    = out_valid && out_ready;
  assign is_last_c   = (idx == LAST_IDX);
  assign idx_inc_c   = idx + AW'(1);
  assign next_last_c = (idx_inc_c == LAST_IDX);

  // Word to load next: first word when idle, otherwise the one after idx.
  assign burst_addr_c = (state == BURST) ? AW'(BASE_ADDR + idx_inc_c) : BASE_ADDR;

`ifdef DATA_MEM_WRITE_GUARD_EN
  logic drop_c;
  assign drop_c  = mem_dout_we && (state == BURST) &&
                   in_window(32'(mem_dout_addr), BURST_BASE, BURST_LEN, AW);
  assign wr_en_c = mem_dout_we && !drop_c;
`else
  assign wr_en_c = mem_dout_we;
`endif

  data_ram #(
    .DATA_ADDR_WIDTH(AW)
  ) u_ram (
    .clk          (clk),
    .we           (wr_en_c),
    .waddr        (mem_dout_addr),
    .wdata        (mem_dout),
    .cpu_addr     (mem_din_addr),
    .cpu_rdata_c  (mem_din),
    .burst_addr   (burst_addr_c),
    .burst_rdata_c(burst_word_c)
  );

  // Burst sequencer with registered stream and resume outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      resume    <= 1'b0;
      overrun   <= 1'b0;
`ifdef DATA_MEM_WRITE_GUARD_EN
      write_conflict <= 1'b0;
`endif
    end else begin
      resume <= 1'b0;
      if (frame_start && (state != IDLE)) overrun <= 1'b1;
`ifdef DATA_MEM_WRITE_GUARD_EN
      if (drop_c) write_conflict <= 1'b1;
`endif
      case (state)
        IDLE: begin
          if (frame_start) begin
            state     <= BURST;
            idx       <= '0;
            out_data  <= burst_word_c;
            out_valid <= 1'b1;
            out_last  <= (BURST_LEN == 32'd1);
          end
        end
        BURST: begin
          if (accept_c) begin
            if (is_last_c) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              resume    <= 1'b1;
              state     <= RESUME;
            end else begin
              idx      <= idx_inc_c;
              out_data <= burst_word_c;
              out_last <= next_last_c;
            end
          end
        end
        RESUME:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_burst_mem.sv
// Randomized scoreboard bench for frame_burst_mem. A transaction-level model
// pushes each expected burst word when it becomes due; a negedge monitor
// compares the stream, resume, overrun and the cpu read port against it.
module tb_frame_burst_mem;

  localparam int unsigned AW    = 13;
  localparam int unsigned BASE  = 32'h1FFE;  // window wraps past the top
  localparam int unsigned LEN   = 5;
  localparam int unsigned DEPTH = 32'd1 << AW;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] mem_din_addr;
  logic [15:0]   mem_din;
  logic          mem_dout_we;
  logic [AW-1:0] mem_dout_addr;
  logic [15:0]   mem_dout;
  logic          frame_start;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_data;
  logic          out_last;
  logic          resume;
  logic          overrun;
`ifdef DATA_MEM_WRITE_GUARD_EN
  logic          write_conflict;
`endif

  frame_burst_mem #(
    .DATA_ADDR_WIDTH(AW),
    .BURST_BASE     (BASE),
    .BURST_LEN      (LEN)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .mem_din_addr (mem_din_addr),
    .mem_din      (mem_din),
    .mem_dout_we  (mem_dout_we),
    .mem_dout_addr(mem_dout_addr),
    .mem_dout     (mem_dout),
    .frame_start  (frame_start),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .resume       (resume),
`ifdef DATA_MEM_WRITE_GUARD_EN
    .write_conflict(write_conflict),
`endif
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_hs  = 0;
  bit check_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] win_addr(input int unsigned k);
    return AW'(BASE + k);
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } beat_t;

  logic [15:0] mram [DEPTH];
  beat_t       exp_q[$];
  bit          m_busy, m_resume, m_ovr, m_conf;
  bit          nxt_resume, drop;
  int unsigned m_beat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy   = 0;
      m_resume = 0;
      m_ovr    = 0;
      m_conf   = 0;
      m_beat   = 0;
      exp_q.delete();
    end else begin
      nxt_resume = 0;
      drop       = 0;
      if (frame_start && (m_busy || m_resume)) m_ovr = 1;
`ifdef DATA_MEM_WRITE_GUARD_EN
      if (mem_dout_we && m_busy && (((32'(mem_dout_addr) - BASE) % DEPTH) < LEN)) begin
        drop   = 1;
        m_conf = 1;
      end
`endif
      if (!m_busy && !m_resume && frame_start) begin
        m_busy = 1;
        m_beat = 0;
        exp_q.push_back({mram[win_addr(0)], 1'(LEN == 1)});
      end else if (m_busy && out_ready) begin
        if (m_beat == LEN - 1) begin
          m_busy     = 0;
          nxt_resume = 1;
        end else begin
          m_beat++;
          exp_q.push_back({mram[win_addr(m_beat)], 1'(m_beat == LEN - 1)});
        end
      end
      m_resume = nxt_resume;
      if (mem_dout_we && !drop) mram[mem_dout_addr] = mem_dout;
    end
  end

  // ---------------- monitor ----------------
  beat_t front;
  always @(negedge clk) begin
    if (rst_n && check_en) begin
      check("mem_din", 32'(mem_din), 32'(mram[mem_din_addr]));
      check("out_valid", 32'(out_valid), 32'(m_busy));
      check("resume", 32'(resume), 32'(m_resume));
      check("overrun", 32'(overrun), 32'(m_ovr));
`ifdef DATA_MEM_WRITE_GUARD_EN
      check("write_conflict", 32'(write_conflict), 32'(m_conf));
`endif
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_empty: got out_data %0h with no expected word at %0t", out_data, $time);
        end else begin
          front = exp_q[0];
          check("out_data", 32'(out_data), 32'(front.data));
          check("out_last", 32'(out_last), 32'(front.last));
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_hs++;
          end
        end
      end else begin
        check("out_last_idle", 32'(out_last), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    frame_start   = 1'b0;
    out_ready     = 1'b0;
    mem_dout_we   = 1'b0;
    mem_dout_addr = '0;
    mem_dout      = '0;
    mem_din_addr  = win_addr(0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"},  32'(out_data),  32'd0);
    check({tag, "_out_last"},  32'(out_last),  32'd0);
    check({tag, "_resume"},    32'(resume),    32'd0);
    check({tag, "_overrun"},   32'(overrun),   32'd0);
  endtask

  task automatic pulse_reset(input string tag);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle_inputs();
    #2;
    check_reset_outputs(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #12;
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Preload the window and its neighbourhood so every checked read is defined.
    for (int k = 0; k < 8; k++) begin
      mem_dout_we   = 1'b1;
      mem_dout_addr = win_addr(k);
      mem_dout      = 16'(32'hA000 + k);
      @(posedge clk);
      #1;
    end
    idle_inputs();
    check_en = 1;

    // Write 'h1234 to 5 while reading 5: old value now, new value next cycle.
    mem_dout_we   = 1'b1;
    mem_dout_addr = AW'(5);
    mem_dout      = 16'h1234;
    mem_din_addr  = AW'(5);
    @(posedge clk);
    #1;
    mem_dout_we = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3000; i++) begin
      if (i == 1000 || i == 2000) begin
        // Abort a burst in flight (bounded wait for one to be running).
        for (int w = 0; w < 200 && !out_valid; w++) begin
          frame_start = 1'b1;
          out_ready   = 1'b0;
          mem_dout_we = 1'b0;
          @(posedge clk);
          #1;
        end
        frame_start = 1'b0;
        out_ready   = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        pulse_reset("abort");
      end
      frame_start   = ($urandom_range(0, 15) == 0);
      out_ready     = ($urandom_range(0, 9) < 6);
      mem_dout_we   = ($urandom_range(0, 2) == 0);
      mem_dout_addr = win_addr($urandom_range(0, 7));
      mem_dout      = 16'($urandom);
      mem_din_addr  = win_addr($urandom_range(0, 7));
      @(posedge clk);
      #1;
    end

    idle_inputs();
    out_ready = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    check("burst_activity", 32'(n_hs > 50), 32'd1);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
